// File: rtl/window_controller.sv
// Sliding-window controller: paces pixel acceptance into a line-buffer chain and
// flags the cycles where the kernel taps hold a complete, stride-aligned window.
module window_controller #(
    parameter int KERNEL_SIZE = 3,
    parameter int ROW_SIZE    = 5,
    parameter int IMG_ROWS    = 5,
    parameter int STRIDE      = 1
) (
    input  logic                          clock,
    input  logic                          sreset_n,
    input  logic                          start,
    input  logic                          pixel_valid,
    output logic                          in_ready,
    output logic                          buffer_shift,
    output logic                          window_valid,
    output logic                          frame_done,
    output logic                          busy,
    output logic [$clog2(ROW_SIZE)-1:0]   col_idx,
    output logic [$clog2(IMG_ROWS)-1:0]   row_idx,
    output logic [1:0]                    state_dbg
);

    localparam int CW = $clog2(ROW_SIZE);
    localparam int RW = $clog2(IMG_ROWS);
    localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(ROW_SIZE - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_ROWS - 1);
    localparam logic [CW-1:0] COL_K1   = CW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] ROW_K1   = RW'(KERNEL_SIZE - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(STRIDE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [PW-1:0]   cph_q, cph_d;
    logic [PW-1:0]   rph_q, rph_d;
    logic            win_q, win_d;
    logic            accept;

    // Handshake: a pixel moves only when pixel_valid and in_ready are both high
    // in the same cycle; in_ready depends on state only, never on pixel_valid.
    assign accept       = pixel_valid && (state_q == S_RUN);
    assign in_ready     = (state_q == S_RUN);
    assign buffer_shift = accept;
    assign busy         = (state_q != S_IDLE);
    assign frame_done   = (state_q == S_DONE);
    assign window_valid = win_q;
    assign col_idx      = col_q;
    assign row_idx      = row_q;
    assign state_dbg    = state_q;

    always_ff @(posedge clock or negedge sreset_n) begin
        if (!sreset_n) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            cph_q   <= '0;
            rph_q   <= '0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cph_q   <= cph_d;
            rph_q   <= rph_d;
            win_q   <= win_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cph_d   = cph_q;
        rph_d   = rph_q;
        win_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    col_d   = '0;
                    row_d   = '0;
                    cph_d   = '0;
                    rph_d   = '0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    // Phase counters hold (c-(K-1)) mod STRIDE and (r-(K-1)) mod STRIDE.
                    win_d = (row_q >= ROW_K1) && (col_q >= COL_K1) &&
                            (rph_q == '0) && (cph_q == '0);
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        cph_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            rph_d   = '0;
                            state_d = S_DONE;
                        end else begin
                            row_d = row_q + 1'b1;
                            if (row_q >= ROW_K1) begin
                                rph_d = (rph_q == PH_LAST) ? '0 : rph_q + 1'b1;
                            end
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                        if (col_q >= COL_K1) begin
                            cph_d = (cph_q == PH_LAST) ? '0 : cph_q + 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/window_controller.md
WINDOW_CONTROLLER -- requirements
Module: window_controller

Interface
REQ-001 The block SHALL have parameter KERNEL_SIZE, default 3, meaning the square kernel edge in pixels.
REQ-002 The block SHALL have parameter ROW_SIZE, default 5, meaning the pixels per image row, equal to the line-buffer depth.
REQ-003 The block SHALL have parameter IMG_ROWS, default 5, meaning the rows per frame.
REQ-004 The block SHALL have parameter STRIDE, default 1, meaning the window step in both directions.
REQ-005 The block SHALL have parameter legality KERNEL_SIZE<=ROW_SIZE, KERNEL_SIZE<=IMG_ROWS and STRIDE>=1; other values are unsupported.
REQ-006 The block SHALL have port clock, input, 1 bit: the single clock, rising edge.
REQ-007 The block SHALL have port sreset_n, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-008 The block SHALL have port start, input, 1 bit: a one-cycle request to begin a frame.
REQ-009 The block SHALL have port pixel_valid, input, 1 bit: the upstream pixel is present.
REQ-010 The block SHALL have port in_ready, output, 1 bit: the controller accepts a pixel this cycle.
REQ-011 The block SHALL have port buffer_shift, output, 1 bit: the shift enable to the data_valid of every line buffer in the window chain.
REQ-012 The block SHALL have port window_valid, output, 1 bit: the kernel_row_out taps hold a complete, stride-aligned window.
REQ-013 The block SHALL have port frame_done, output, 1 bit: a one-cycle pulse when the frame ends.
REQ-014 The block SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-015 The block SHALL have port col_idx, output, $clog2(ROW_SIZE) bits: the column of the next pixel to accept.
REQ-016 The block SHALL have port row_idx, output, $clog2(IMG_ROWS) bits: the row of the next pixel to accept.

Function
REQ-017 FSM states SHALL be IDLE, RUN and DONE.
- IDLE->RUN on start.
- RUN->DONE on acceptance of pixel (IMG_ROWS-1, ROW_SIZE-1).
- DONE->IDLE unconditionally after one cycle.
REQ-018 Entry to RUN SHALL clear col_idx and row_idx to 0 and the stride-phase counters to 0.
REQ-019 in_ready SHALL be 1 only in RUN and 0 in IDLE and DONE.
REQ-020 Acceptance SHALL be defined as pixel_valid && in_ready.
- buffer_shift SHALL equal acceptance combinationally in the same cycle.
- buffer_shift SHALL never be 1 without acceptance.
REQ-021 On acceptance, col_idx SHALL increment; at ROW_SIZE-1 it SHALL wrap to 0 and row_idx SHALL increment. Counters SHALL hold when there is no acceptance.
REQ-022 window_valid SHALL be registered: 1 for exactly the cycle after accepting pixel (r,c) when all of the following hold, otherwise 0:
- r>=KERNEL_SIZE-1
- c>=KERNEL_SIZE-1
- (r-(KERNEL_SIZE-1)) mod STRIDE==0
- (c-(KERNEL_SIZE-1)) mod STRIDE==0
REQ-023 The stride test SHALL use column and row phase counters, not division.
- Column phase SHALL reset at each row wrap.
- Row phase SHALL advance only on row wrap once r>=KERNEL_SIZE-1.
REQ-024 Windows per frame SHALL be floor((ROW_SIZE-KERNEL_SIZE)/STRIDE+1) * floor((IMG_ROWS-KERNEL_SIZE)/STRIDE+1).
REQ-025 frame_done SHALL be 1 exactly in the DONE cycle.
- The final window_valid, if any, coincides with frame_done.
REQ-026 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-027 start SHALL be ignored in RUN and DONE. start is honoured only in IDLE, including the cycle immediately after DONE.
REQ-028 pixel_valid in IDLE or DONE SHALL cause no shift, no counter change and no window_valid.
REQ-029 Gaps in pixel_valid (any length) SHALL stall all counters and emit no window_valid.
- Window positions SHALL be identical to the gapless stream.

Reset
REQ-030 sreset_n low SHALL asynchronously force the following, regardless of state, including mid-frame:
- FSM=IDLE
- in_ready=0, buffer_shift=0, window_valid=0, frame_done=0, busy=0
- col_idx=0, row_idx=0, all phase counters=0
REQ-031 After reset release, the block SHALL wait in IDLE for start. Line-buffer contents are not cleared by this block.

Verification
REQ-032 Defaults, start, 25 back-to-back pixels -> first window_valid the cycle after pixel 13 (r=2,c=2); 9 pulses total; frame_done the cycle after pixel 25; busy low the cycle after that.
REQ-033 STRIDE=2, 25 pixels -> exactly 4 window_valid pulses, after pixels (2,2), (2,4), (4,2), (4,4).
REQ-034 Defaults, pixel_valid toggled 1/0 every cycle -> buffer_shift mirrors accepted beats only; 9 windows at the same pixel indices as REQ-032; frame_done after the 25th accepted pixel.
REQ-035 sreset_n pulsed low after 10 pixels -> all outputs 0 within the reset; IDLE; new start plus 25 pixels reproduces REQ-032 exactly.
REQ-036 start asserted again at pixel 5 and in the DONE cycle -> no counter clear, no extra frame; start one cycle after DONE -> new frame begins with col_idx=0, row_idx=0.
